hazard_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage CPU. It is the producer-side counterpart of the forwarding unit: it detects the hazards that forwarding cannot resolve and throttles the pipeline.
- Load-use: inserts one bubble.
- Multi-cycle data-memory access: freezes the whole pipeline until memory is ready, with a timeout.
- Taken branch in ID: flushes IF/ID.
It sits beside the forwarding unit and drives the PC and pipeline-register enable/flush controls. It also keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage CPU.
// It stalls the pipeline for load-use hazards with a single bubble and
// freezes it while the data memory is busy, flagging a sticky error if
// the wait exceeds TIMEOUT. It flushes IF/ID on a taken branch and keeps
// a saturating count of the cycles in which the PC was held.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       IF_ID_RSaddr_i,
  input  logic [4:0]       IF_ID_RTaddr_i,
  input  logic             ID_UseRS_i,
  input  logic             ID_UseRT_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [4:0]       ID_EX_RTaddr_i,
  input  logic             Branch_i,
  input  logic             EX_MEM_MemAccess_i,
  input  logic             DMEM_Ready_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Flush_o,
  output logic             Freeze_o,
  output logic             Mem_Err_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  // Wait counter must be able to hold the value TIMEOUT itself.
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_VAL = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic              r_mem_err;
  logic              w_mem_err_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_memwait;
  logic w_loaduse;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_memwait = EX_MEM_MemAccess_i & ~DMEM_Ready_i;
  assign w_rs_hit  = ID_UseRS_i & (IF_ID_RSaddr_i == ID_EX_RTaddr_i);
  assign w_rt_hit  = ID_UseRT_i & (IF_ID_RTaddr_i == ID_EX_RTaddr_i);
  // A load targeting $0 produces nothing to wait for, so it never stalls.
  assign w_loaduse = ID_EX_MemRead_i & (ID_EX_RTaddr_i != 5'd0) & (w_rs_hit | w_rt_hit);

  // Next-state logic and same-cycle pipeline controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_mem_err_nxt = r_mem_err;
    PC_Write_o    = 1'b0;
    IF_ID_Write_o = 1'b0;
    IF_ID_Flush_o = 1'b0;
    ID_EX_Flush_o = 1'b0;
    Freeze_o      = 1'b0;

    unique case (r_state)
      RUN, MEM_WAIT: begin
        if ((r_state == RUN && w_memwait) ||
            (r_state == MEM_WAIT && !DMEM_Ready_i)) begin
          // Memory busy: hold everything, branch waits for the release.
          Freeze_o = 1'b1;
          if (r_state == RUN) begin
            w_wcnt_nxt  = WCNT_W'(1);
            w_state_nxt = MEM_WAIT;
          end else if (r_wcnt == TO_VAL) begin
            w_state_nxt   = ERROR;
            w_mem_err_nxt = 1'b1;
          end else begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          end
        end else begin
          // Running, or memory released this cycle: normal priority rules.
          if (r_state == MEM_WAIT) begin
            w_state_nxt = RUN;
            w_wcnt_nxt  = '0;
          end
          if (w_loaduse) begin
            ID_EX_Flush_o = 1'b1;
          end else begin
            PC_Write_o    = 1'b1;
            IF_ID_Write_o = 1'b1;
            IF_ID_Flush_o = Branch_i;
          end
        end
      end
      ERROR: begin
        Freeze_o = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase

    // Keep the pipeline quiet while reset is held.
    if (!rst_i) begin
      PC_Write_o    = 1'b0;
      IF_ID_Write_o = 1'b0;
      IF_ID_Flush_o = 1'b0;
      ID_EX_Flush_o = 1'b0;
      Freeze_o      = 1'b0;
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= RUN;
      r_wcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (!PC_Write_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign Mem_Err_o   = rst_i & r_mem_err;
  assign Stall_Cnt_o = r_stall_cnt;

endmodule
